// File: rtl/flash_pkg.sv
// Shared constants and FSM encoding for flash_reader.
// Build option FLASH_FAST_READ_EN selects FAST_READ (0x0B) with one dummy byte.
package flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OP_CODE = OP_FAST_READ;
`else
    localparam logic [7:0] OP_CODE = OP_READ;
`endif

    // Cycles CYC_O stays low after the last byte; the final one carries done.
    localparam logic [1:0] GAP_LEN = 2'd2;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CMD   = 4'd1,
        ADR2  = 4'd2,
        ADR1  = 4'd3,
        ADR0  = 4'd4,
`ifdef FLASH_FAST_READ_EN
        DUMMY = 4'd5,
`endif
        DATA  = 4'd6,
        HOLD  = 4'd7,
        GAP   = 4'd8
    } state_t;

    function automatic logic [7:0] slot_byte(input state_t st, input logic [23:0] a);
        logic [7:0] b;
        case (st)
            CMD:     b = OP_CODE;
            ADR2:    b = a[23:16];
            ADR1:    b = a[15:8];
            ADR0:    b = a[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_reader_wb_byte_slot.sv
// One Wishbone byte slot: STB_O/WE_O/DAT_O held from go until ACK_I, then
// dropped for at least one cycle because go is only honoured while idle.
module wb_byte_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       ack_in,
    output logic       stb,
    output logic       we,
    output logic [7:0] dat,
    output logic       ack_ok
);

    // An ack seen while the strobe is low is not a completion.
    assign ack_ok = stb & ack_in;

    // Strobe/data register for the current slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb <= 1'b0;
            we  <= 1'b0;
            dat <= 8'h00;
        end else if (stb) begin
            if (ack_in) begin
                stb <= 1'b0;
                we  <= 1'b0;
            end else begin
                stb <= 1'b1;
                we  <= 1'b1;
            end
        end else if (go) begin
            stb <= 1'b1;
            we  <= 1'b1;
            dat <= tx_byte;
        end else begin
            stb <= 1'b0;
            we  <= 1'b0;
        end
    end

endmodule

// File: rtl/flash_reader.sv
// SPI flash read sequencer driving a Wishbone byte engine.
// Optional FLASH_FAST_READ_EN: FAST_READ opcode plus one dummy byte before data.
module flash_reader
    import flash_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    input  logic             rd_ready,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    output logic [7:0]       DAT_O,
    input  logic [7:0]       DAT_I,
    input  logic             ACK_I
);

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic             busy_nx, done_nx, cyc_nx, valid_nx;
    logic [7:0]       data_nx;
    logic [23:0]      addr_q, addr_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic [1:0]       gap_cnt, gap_nx;
    logic             go, slot_ack;
    logic [7:0]       tx_byte;

    assign tx_byte = slot_byte(state, addr_q);

    wb_byte_slot u_slot (
        .clk     (CLK_I),
        .rst     (RST_I),
        .go      (go),
        .tx_byte (tx_byte),
        .ack_in  (ACK_I),
        .stb     (STB_O),
        .we      (WE_O),
        .dat     (DAT_O),
        .ack_ok  (slot_ack)
    );

    // State and registered outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            CYC_O     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            addr_q    <= 24'h000000;
            remaining <= '0;
            gap_cnt   <= 2'd0;
        end else begin
            state     <= state_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            CYC_O     <= cyc_nx;
            rd_valid  <= valid_nx;
            rd_data   <= data_nx;
            addr_q    <= addr_nx;
            remaining <= remaining_nx;
            gap_cnt   <= gap_nx;
        end
    end

    // Next-state and next-output logic; a new slot is requested only while STB_O is low.
    always_comb begin
        state_nx     = state;
        busy_nx      = busy;
        done_nx      = 1'b0;
        cyc_nx       = CYC_O;
        valid_nx     = rd_valid;
        data_nx      = rd_data;
        addr_nx      = addr_q;
        remaining_nx = remaining;
        gap_nx       = gap_cnt;
        go           = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nx     = CMD;
                    busy_nx      = 1'b1;
                    cyc_nx       = 1'b1;
                    addr_nx      = addr;
                    remaining_nx = len;
                end else begin
                    done_nx = start;
                end
            end
            CMD: begin
                go       = ~STB_O;
                state_nx = slot_ack ? ADR2 : CMD;
            end
            ADR2: begin
                go       = ~STB_O;
                state_nx = slot_ack ? ADR1 : ADR2;
            end
            ADR1: begin
                go       = ~STB_O;
                state_nx = slot_ack ? ADR0 : ADR1;
            end
`ifdef FLASH_FAST_READ_EN
            ADR0: begin
                go       = ~STB_O;
                state_nx = slot_ack ? DUMMY : ADR0;
            end
            DUMMY: begin
                go       = ~STB_O;
                state_nx = slot_ack ? DATA : DUMMY;
            end
`else
            ADR0: begin
                go       = ~STB_O;
                state_nx = slot_ack ? DATA : ADR0;
            end
`endif
            DATA: begin
                go = ~STB_O;
                if (slot_ack) begin
                    state_nx     = HOLD;
                    valid_nx     = 1'b1;
                    data_nx      = DAT_I;
                    remaining_nx = remaining - ONE;
                end else begin
                    state_nx = DATA;
                end
            end
            HOLD: begin
                // The next data slot waits for the consumer, so SCK idles while stalled.
                if (rd_ready) begin
                    valid_nx = 1'b0;
                    if (remaining == '0) begin
                        state_nx = GAP;
                        cyc_nx   = 1'b0;
                        gap_nx   = GAP_LEN - 2'd1;
                    end else begin
                        state_nx = DATA;
                    end
                end else begin
                    state_nx = HOLD;
                end
            end
            GAP: begin
                if (gap_cnt <= 2'd1) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    gap_nx = gap_cnt - 2'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_reader.sv
// Randomized scoreboard bench for flash_reader with a behavioural SPI flash engine.
module tb_flash_reader;

    localparam int LEN_W = 16;
`ifdef FLASH_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic             CLK_I = 1'b0;
    logic             RST_I = 1'b1;
    logic             start = 1'b0;
    logic [23:0]      addr  = 24'h0;
    logic [LEN_W-1:0] len   = '0;
    logic             busy, done, rd_valid, CYC_O, STB_O, WE_O;
    logic [7:0]       rd_data, DAT_O;
    logic             rd_ready = 1'b0;
    logic [7:0]       DAT_I    = 8'h00;
    logic             ACK_I    = 1'b0;

    flash_reader #(.LEN_W(LEN_W)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ready(rd_ready), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [7:0] wire_q[$];
    logic [7:0] rd_q[$];
    bit   pending = 1'b0;
    int   exp_done = -1;
    int   done_count = 0, cyc_hi = 0, slot_rises = 0;
    int   idx = 0, ack_wait = 0, stall_left = 0;
    logic [23:0] eaddr = 24'h0;
    bit   slow_ack = 1'b0, ready_rand = 1'b0, stall_arm = 1'b0;
    logic [7:0] held = 8'h00, held_dat = 8'h00;
    logic prev_stb = 1'b0, prev_ack = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'hA5;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge CLK_I) cyc <= cyc + 1;

    // Flash engine, consumer and monitor: drive inputs for the next edge, then check.
    always @(negedge CLK_I) begin
        if (!CYC_O) idx = 0;
        ACK_I = 1'b0;
        DAT_I = 8'($urandom);
        if (STB_O) begin
            if (ack_wait <= 0) begin
                ACK_I = 1'b1;
                if (idx >= 1 && idx <= 3) eaddr[8*(3-idx) +: 8] = DAT_O;
                if (idx >= HDR) DAT_I = mem_byte(eaddr + 24'(idx - HDR));
                idx++;
                ack_wait = slow_ack ? 10 : int'($urandom_range(0, 2));
            end else begin
                ack_wait--;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            ACK_I = 1'b1;
        end

        if (stall_arm && rd_valid) begin
            stall_arm  = 1'b0;
            stall_left = 20;
            held       = rd_data;
        end
        if (stall_left > 0) begin
            rd_ready = 1'b0;
            chk("stall_rd_data", 32'(rd_data), 32'(held));
            chk("stall_rd_valid", 32'(rd_valid), 32'd1);
            chk("stall_stb_low", 32'(STB_O), 32'd0);
            chk("stall_cyc_high", 32'(CYC_O), 32'd1);
            stall_left--;
        end else begin
            rd_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        if (CYC_O) cyc_hi++;
        if (STB_O) chk("we_with_stb", 32'(WE_O), 32'd1);
        if (prev_ack) chk("stb_low_after_ack", 32'(STB_O), 32'd0);
        if (STB_O && !prev_stb) begin
            slot_rises++;
            chk("slot_expected", 32'(wire_q.size() != 0), 32'd1);
            if (wire_q.size() != 0) chk("slot_byte", 32'(DAT_O), 32'(wire_q.pop_front()));
            held_dat = DAT_O;
        end else if (STB_O) begin
            chk("slot_stable", 32'(DAT_O), 32'(held_dat));
        end
        if (rd_valid && rd_ready) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
                if (rd_q.size() == 0 && pending) exp_done = cyc + 2;
            end
        end
        if (done) begin
            done_count++;
            chk("done_expected", 32'(pending), 32'd1);
            chk("done_cycle", 32'(cyc), 32'(exp_done));
            chk("done_all_bytes", 32'(rd_q.size() + wire_q.size()), 32'd0);
            pending = 1'b0;
        end
        prev_stb = STB_O;
        prev_ack = STB_O && ACK_I;
    end

    task automatic issue(input logic [23:0] a, input logic [LEN_W-1:0] n);
        @(negedge CLK_I);
        start = 1'b1;
        addr  = a;
        len   = n;
        if (n != '0) begin
            wire_q.push_back(OPC);
            wire_q.push_back(a[23:16]);
            wire_q.push_back(a[15:8]);
            wire_q.push_back(a[7:0]);
            if (HDR == 5) wire_q.push_back(8'h00);
            for (int k = 0; k < int'(n); k++) begin
                wire_q.push_back(8'h00);
                rd_q.push_back(mem_byte(a + 24'(k)));
            end
            exp_done = -1;
        end else begin
            exp_done = cyc + 1;
        end
        pending = 1'b1;
        @(negedge CLK_I);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (pending && t < 3000) begin
            @(posedge CLK_I);
            #1;
            t++;
        end
        chk(tag, 32'(pending), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        repeat (2) @(posedge CLK_I);
    endtask

    initial begin
        int base, t, dc;
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cyc", 32'(CYC_O), 32'd0);
        chk("rst_stb", 32'(STB_O), 32'd0);
        chk("rst_we", 32'(WE_O), 32'd0);
        chk("rst_dat_o", 32'(DAT_O), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;

        // Basic read, consumer always ready
        issue(24'h012345, 16'd3);
        chk("busy_during", 32'(busy), 32'd1);
        chk("cyc_during", 32'(CYC_O), 32'd1);
        wait_done("timeout_basic");

        // Zero length: done only, no bus cycle
        t = cyc_hi;
        issue(24'h001000, 16'd0);
        wait_done("timeout_len0");
        chk("len0_no_cyc", 32'(cyc_hi - t), 32'd0);

        // Consumer stall after the first byte
        stall_arm = 1'b1;
        issue(24'h00FF00, 16'd2);
        wait_done("timeout_stall");
        chk("stall_ran", 32'(stall_arm), 32'd0);

        // Start while busy is ignored
        dc = done_count;
        issue(24'h777777, 16'd2);
        @(negedge CLK_I);
        chk("busy_at_restart", 32'(busy), 32'd1);
        start = 1'b1; addr = 24'h111111; len = 16'd5;
        @(negedge CLK_I);
        start = 1'b0;
        wait_done("timeout_restart");
        repeat (10) @(posedge CLK_I);
        chk("single_done", 32'(done_count - dc), 32'd1);

        // Reset in the middle of ADR1
        slow_ack = 1'b1;
        base = slot_rises;
        issue(24'hABCDEF, 16'd4);
        t = 0;
        while (slot_rises < base + 3 && t < 500) begin
            @(posedge CLK_I);
            #1;
            t++;
        end
        chk("reach_adr1", 32'(slot_rises - base), 32'd3);
        @(negedge CLK_I);
        RST_I = 1'b1;
        wire_q.delete();
        rd_q.delete();
        pending = 1'b0;
        @(posedge CLK_I);
        #1;
        chk("midrst_cyc", 32'(CYC_O), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stb", 32'(STB_O), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;
        slow_ack = 1'b0;
        issue(24'hABCDEF, 16'd4);
        wait_done("timeout_after_rst");

        // Address wrap at the top of the device
        issue(24'hFFFFFF, 16'd2);
        wait_done("timeout_wrap");

        // Random reads with a random consumer
        ready_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue((i % 4 == 0) ? 24'hFFFFFE : 24'($urandom), 16'($urandom_range(1, 6)));
            wait_done("timeout_random");
        end
        ready_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, giving the width of the byte-count input.
REQ-002 The block SHALL have port CLK_I, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port RST_I, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle pulse requesting a read.
REQ-005 The block SHALL have port addr, input, 24, the flash start address, sampled on start.
REQ-006 The block SHALL have port len, input, LEN_W, the byte count, sampled on start.
REQ-007 The block SHALL have port busy, output, 1, high from accepted start until completion.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have ports rd_valid (output, 1), rd_data (output, 8) and rd_ready (input, 1), forming the read-byte stream; a transfer occurs when rd_valid and rd_ready are both high.
REQ-010 The block SHALL have Wishbone master ports to the SPI byte engine: CYC_O, STB_O and WE_O (output, 1 each), DAT_O (output, 8, byte to shift out), DAT_I (input, 8, byte shifted in) and ACK_I (input, 1).

Function
REQ-011 The FSM states SHALL be IDLE, CMD, ADR2, ADR1, ADR0, DUMMY (macro only), DATA, HOLD and GAP.
REQ-012 In IDLE, start with len!=0 SHALL latch addr/len, raise busy and CYC_O, and enter CMD on the next cycle.
REQ-013 Start with len==0 SHALL pulse done one cycle later and drive no Wishbone activity.
REQ-014 Start SHALL be ignored while busy is high.
REQ-015 Each byte slot SHALL assert STB_O with DAT_O stable until ACK_I, deassert STB_O on the cycle after ACK_I, and hold STB_O low for at least one cycle before the next slot.
REQ-016 WE_O SHALL be driven high whenever STB_O is high.
REQ-017 The byte sequence SHALL be: CMD sends opcode READ (0x03); ADR2, ADR1 and ADR0 send addr[23:16], addr[15:8] and addr[7:0]; DATA sends 0x00.
REQ-018 In DATA, on ACK_I the block SHALL capture DAT_I into rd_data, assert rd_valid, decrement the remaining count and enter HOLD.
REQ-019 In HOLD, rd_valid SHALL stay high with rd_data stable until the rd_ready handshake; the next DATA slot SHALL NOT start before the handshake, so CYC_O stays high with no SCK activity while stalled.
REQ-020 When the remaining count reaches 0 and the last byte has been accepted, the block SHALL drop CYC_O and enter GAP.
REQ-021 GAP SHALL hold CYC_O low for 2 cycles, then pulse done, drop busy and return to IDLE.
REQ-022 The remaining-count counter SHALL be LEN_W bits, SHALL NOT wrap, and the maximum count 2^LEN_W-1 SHALL be supported.
REQ-023 The address SHALL NOT be incremented by the block; the flash auto-increments across the whole read, including at wrap past 0xFFFFFF.
REQ-024 An ACK_I arriving while STB_O is low SHALL be ignored.

Reset
REQ-025 On RST_I high at a rising edge, the block SHALL force the state to IDLE and drive CYC_O=0, STB_O=0, WE_O=0, DAT_O=0, busy=0, done=0, rd_valid=0 and rd_data=0, including when reset occurs mid-transaction.
REQ-026 After reset, the first start SHALL be accepted no earlier than the cycle after RST_I falls.

Configuration
REQ-027 With FLASH_FAST_READ_EN defined, CMD SHALL send opcode FAST_READ (0x0B) and DUMMY SHALL send one 0x00 byte after ADR0, with no rd_valid, before DATA.
REQ-028 Without FLASH_FAST_READ_EN, the DUMMY state SHALL be absent and the opcode SHALL be 0x03.

Structure
REQ-029 A shared package flash_pkg SHALL hold the opcode constants (OP_READ=0x03, OP_FAST_READ=0x0B), the FSM state encoding and the GAP length constant (2).
REQ-030 The byte-slot strobe/ack handshake of REQ-015 SHALL be a sub-module wb_byte_slot, instantiated once.

Verification
REQ-031 Start addr=0x012345, len=3, rd_ready=1, with a behavioural SPI engine -> DAT_O sequence 03,01,23,45,00,00,00; 3 rd_valid bytes; done 3 cycles after the last ACK_I.
REQ-032 Start with len=0 -> done 1 cycle later; CYC_O never asserted.
REQ-033 len=2, rd_ready held low 20 cycles after the first byte -> rd_data stable, STB_O low and CYC_O high throughout; second slot starts after the handshake.
REQ-034 RST_I pulsed during ADR1 -> CYC_O, busy and STB_O are 0 the next cycle; a new start then runs the full sequence from CMD.
REQ-035 Build with FLASH_FAST_READ_EN, addr=0xFFFFFF, len=2 -> DAT_O sequence 0B,FF,FF,FF,00,00,00; 2 bytes delivered.
REQ-036 Start pulsed again while busy -> ignored; exactly one done.
